// File: rtl/weight_row_bpeb_loader.sv
// weight_row_bpeb_loader: accepts one kernel row of weights on a valid/ready stream,
// BPEB-encodes each tap on arrival into a shadow bank, and promotes the shadow bank
// to the active bank on a swap request so the next row can load while this one computes.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   load_start_i           pulse; start loading a row (bcast_mode_i, kernel_size_i, n_ap_i sampled)
//   w_in_valid_i/_data_i   weight beat stream; w_in_ready_o high exactly while loading
//   wregs_swap_i           pulse; commit shadow bank to active bank
//   load_done_o            one-cycle pulse when the shadow bank is complete
//   shadow_valid_o         shadow bank holds an uncommitted row
//   busy_o                 loading
//   wregs_o/wbprs_o/wetcs_o active raw / encoded / effective-term-count per column and tap
//   col_all_zero_o         active column has every tap ETC equal to 0
//
// Bank layout: column c, tap t lives in slot c*NbTaps+t of each flat output vector.
module weight_row_bpeb_loader #(
    parameter int unsigned NumPeCol       = 4,
    parameter int unsigned NbTaps         = 11,
    parameter int unsigned WeightWidth    = 16,
    parameter int unsigned WeightBprWidth = ((WeightWidth + 1) / 2) * 3,
    parameter int unsigned EtcWidth       = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        load_start_i,
    input  logic                                        bcast_mode_i,
    input  logic [3:0]                                  kernel_size_i,
    input  logic [3:0]                                  n_ap_i,
    input  logic                                        w_in_valid_i,
    input  logic [WeightWidth-1:0]                      w_in_data_i,
    output logic                                        w_in_ready_o,
    input  logic                                        wregs_swap_i,
    output logic                                        load_done_o,
    output logic                                        shadow_valid_o,
    output logic                                        busy_o,
    output logic [NumPeCol*WeightWidth*NbTaps-1:0]      wregs_o,
    output logic [NumPeCol*WeightBprWidth*NbTaps-1:0]   wbprs_o,
    output logic [NumPeCol*EtcWidth*NbTaps-1:0]         wetcs_o,
    output logic [NumPeCol-1:0]                         col_all_zero_o
);

    localparam int unsigned NumGroups = WeightBprWidth / 3;
    localparam int unsigned ColW      = (NumPeCol > 1) ? $clog2(NumPeCol) : 1;
    localparam int unsigned RawW      = NumPeCol * NbTaps * WeightWidth;
    localparam int unsigned BprW      = NumPeCol * NbTaps * WeightBprWidth;
    localparam int unsigned EtcW      = NumPeCol * NbTaps * EtcWidth;

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

    state_e              state_q, state_d;
    logic [3:0]          tap_q, tap_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [3:0]          ks_q, ks_d;
    logic [3:0]          nap_q, nap_d;
    logic                bcast_q, bcast_d;
    logic                load_done_q, load_done_d;
    logic [RawW-1:0]     sh_raw_q, sh_raw_d, act_raw_q, act_raw_d;
    logic [BprW-1:0]     sh_bpr_q, sh_bpr_d, act_bpr_q, act_bpr_d;
    logic [EtcW-1:0]     sh_etc_q, sh_etc_d, act_etc_q, act_etc_d;
    logic [NumPeCol-1:0] caz_q, caz_d;

    // Encoder: group i looks at data bits {2i+1, 2i, 2i-1}; a zero is shifted in below bit 0.
    logic [2*NumGroups:0]      w_ext;
    logic [WeightBprWidth-1:0] enc_bpr;
    logic [EtcWidth-1:0]       enc_etc;
    logic [2:0]                grp;

    always_comb begin
        w_ext = '0;
        w_ext[WeightWidth:1] = w_in_data_i;
        enc_bpr = '0;
        enc_etc = '0;
        grp     = '0;
        for (int i = 0; i < NumGroups; i++) begin
            grp = w_ext[2*i +: 3];
            if (i < int'(nap_q)) begin
                grp = 3'b000;
            end
            enc_bpr[3*i +: 3] = grp;
            // 000 and 111 contribute no effective term
            if (grp != 3'b000 && grp != 3'b111) begin
                enc_etc = enc_etc + EtcWidth'(1);
            end
        end
    end

    logic accept, last_beat, commit, start_ok;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        col_d       = col_q;
        ks_d        = ks_q;
        nap_d       = nap_q;
        bcast_d     = bcast_q;
        load_done_d = 1'b0;
        sh_raw_d    = sh_raw_q;
        sh_bpr_d    = sh_bpr_q;
        sh_etc_d    = sh_etc_q;
        act_raw_d   = act_raw_q;
        act_bpr_d   = act_bpr_q;
        act_etc_d   = act_etc_q;
        caz_d       = caz_q;
        start_ok    = 1'b0;

        accept    = (state_q == StLoad) && w_in_valid_i;
        last_beat = (tap_q == ks_q - 4'd1) && (bcast_q || col_q == ColW'(NumPeCol - 1));
        commit    = (state_q == StFull) && wregs_swap_i;

        unique case (state_q)
            StIdle: begin
                start_ok = load_start_i;
            end
            StLoad: begin
                if (accept) begin
                    for (int c = 0; c < NumPeCol; c++) begin
                        for (int t = 0; t < NbTaps; t++) begin
                            if (t == int'(tap_q) && (bcast_q || c == int'(col_q))) begin
                                sh_raw_d[(c*NbTaps+t)*WeightWidth +: WeightWidth]       = w_in_data_i;
                                sh_bpr_d[(c*NbTaps+t)*WeightBprWidth +: WeightBprWidth] = enc_bpr;
                                sh_etc_d[(c*NbTaps+t)*EtcWidth +: EtcWidth]             = enc_etc;
                            end
                        end
                    end
                    if (last_beat) begin
                        state_d     = StFull;
                        load_done_d = 1'b1;
                    end else if (tap_q == ks_q - 4'd1) begin
                        tap_d = '0;
                        col_d = col_q + ColW'(1);
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
            end
            StFull: begin
                if (commit) begin
                    // Commit uses the pre-clear shadow even when a new load starts this edge
                    act_raw_d = sh_raw_q;
                    act_bpr_d = sh_bpr_q;
                    act_etc_d = sh_etc_q;
                    for (int c = 0; c < NumPeCol; c++) begin
                        caz_d[c] = (sh_etc_q[c*NbTaps*EtcWidth +: NbTaps*EtcWidth] == '0);
                    end
                    state_d  = StIdle;
                    start_ok = load_start_i;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_ok) begin
            state_d  = StLoad;
            ks_d     = kernel_size_i;
            nap_d    = n_ap_i;
            bcast_d  = bcast_mode_i;
            tap_d    = '0;
            col_d    = '0;
            sh_raw_d = '0;
            sh_bpr_d = '0;
            sh_etc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            col_q       <= '0;
            ks_q        <= '0;
            nap_q       <= '0;
            bcast_q     <= 1'b0;
            load_done_q <= 1'b0;
            sh_raw_q    <= '0;
            sh_bpr_q    <= '0;
            sh_etc_q    <= '0;
            act_raw_q   <= '0;
            act_bpr_q   <= '0;
            act_etc_q   <= '0;
            caz_q       <= '1;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            col_q       <= col_d;
            ks_q        <= ks_d;
            nap_q       <= nap_d;
            bcast_q     <= bcast_d;
            load_done_q <= load_done_d;
            sh_raw_q    <= sh_raw_d;
            sh_bpr_q    <= sh_bpr_d;
            sh_etc_q    <= sh_etc_d;
            act_raw_q   <= act_raw_d;
            act_bpr_q   <= act_bpr_d;
            act_etc_q   <= act_etc_d;
            caz_q       <= caz_d;
        end
    end

    assign w_in_ready_o   = (state_q == StLoad);
    assign busy_o         = (state_q == StLoad);
    assign shadow_valid_o = (state_q == StFull);
    assign load_done_o    = load_done_q;
    assign wregs_o        = act_raw_q;
    assign wbprs_o        = act_bpr_q;
    assign wetcs_o        = act_etc_q;
    assign col_all_zero_o = caz_q;

endmodule

// File: tb/tb_weight_row_bpeb_loader.sv
// Scoreboard bench for weight_row_bpeb_loader: stimulus pushes expected load_done events
// and expected active banks; a negedge monitor pops and compares whenever the DUT pulses
// load_done or its active bank outputs change.
module tb_weight_row_bpeb_loader;

    localparam int NC   = 4;
    localparam int NT   = 11;
    localparam int WW   = 16;
    localparam int BW   = 24;
    localparam int EW   = 4;
    localparam int RAWW = NC * NT * WW;
    localparam int BPRW = NC * NT * BW;
    localparam int ETCW = NC * NT * EW;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            load_start_i;
    logic            bcast_mode_i;
    logic [3:0]      kernel_size_i;
    logic [3:0]      n_ap_i;
    logic            w_in_valid_i;
    logic [WW-1:0]   w_in_data_i;
    logic            w_in_ready_o;
    logic            wregs_swap_i;
    logic            load_done_o;
    logic            shadow_valid_o;
    logic            busy_o;
    logic [RAWW-1:0] wregs_o;
    logic [BPRW-1:0] wbprs_o;
    logic [ETCW-1:0] wetcs_o;
    logic [NC-1:0]   col_all_zero_o;

    weight_row_bpeb_loader dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .load_start_i   (load_start_i),
        .bcast_mode_i   (bcast_mode_i),
        .kernel_size_i  (kernel_size_i),
        .n_ap_i         (n_ap_i),
        .w_in_valid_i   (w_in_valid_i),
        .w_in_data_i    (w_in_data_i),
        .w_in_ready_o   (w_in_ready_o),
        .wregs_swap_i   (wregs_swap_i),
        .load_done_o    (load_done_o),
        .shadow_valid_o (shadow_valid_o),
        .busy_o         (busy_o),
        .wregs_o        (wregs_o),
        .wbprs_o        (wbprs_o),
        .wetcs_o        (wetcs_o),
        .col_all_zero_o (col_all_zero_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [RAWW-1:0] raw;
        logic [BPRW-1:0] bpr;
        logic [ETCW-1:0] etc;
        logic [NC-1:0]   caz;
        bit              chk_lat;
        int              id;
    } bank_t;

    bank_t bank_q[$];
    int    done_q[$];
    bank_t act_model;

    logic [WW-1:0] m_raw [NC][NT];
    logic [BW-1:0] m_bpr [NC][NT];
    logic [EW-1:0] m_etc [NC][NT];

    // Hand-encoded BPEB values for data 1..8 with n_ap = 0
    logic [BW-1:0] enc8_bpr [8] = '{24'h2, 24'hC, 24'hE, 24'h10, 24'h12, 24'h1C, 24'h1E, 24'h60};
    logic [EW-1:0] enc8_etc [8] = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_bank(input string name, input bank_t e);
        bit ok;
        ok = 1'b1;
        for (int s = 0; s < NC * NT; s++) begin
            if (ok && wregs_o[s*WW +: WW] !== e.raw[s*WW +: WW]) begin
                ok = 1'b0;
                $display("FAIL %s raw col%0d tap%0d: actual %0h required %0h", name, s / NT,
                         s % NT, wregs_o[s*WW +: WW], e.raw[s*WW +: WW]);
            end
        end
        n_checks++;
        if (!ok) n_fail++;
        ok = 1'b1;
        for (int s = 0; s < NC * NT; s++) begin
            if (ok && wbprs_o[s*BW +: BW] !== e.bpr[s*BW +: BW]) begin
                ok = 1'b0;
                $display("FAIL %s bpr col%0d tap%0d: actual %0h required %0h", name, s / NT,
                         s % NT, wbprs_o[s*BW +: BW], e.bpr[s*BW +: BW]);
            end
        end
        n_checks++;
        if (!ok) n_fail++;
        ok = 1'b1;
        for (int s = 0; s < NC * NT; s++) begin
            if (ok && wetcs_o[s*EW +: EW] !== e.etc[s*EW +: EW]) begin
                ok = 1'b0;
                $display("FAIL %s etc col%0d tap%0d: actual %0h required %0h", name, s / NT,
                         s % NT, wetcs_o[s*EW +: EW], e.etc[s*EW +: EW]);
            end
        end
        n_checks++;
        if (!ok) n_fail++;
        check({name, " col_all_zero"}, 32'(col_all_zero_o), 32'(e.caz));
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            for (int t = 0; t < NT; t++) begin
                m_raw[c][t] = '0;
                m_bpr[c][t] = '0;
                m_etc[c][t] = '0;
            end
        end
    endtask

    task automatic model_bcast(input int t, input logic [WW-1:0] raw, input logic [BW-1:0] bpr,
                               input logic [EW-1:0] etc);
        for (int c = 0; c < NC; c++) begin
            m_raw[c][t] = raw;
            m_bpr[c][t] = bpr;
            m_etc[c][t] = etc;
        end
    endtask

    task automatic model_percol();
        model_clear();
        for (int c = 0; c < NC; c++) begin
            for (int t = 0; t < 2; t++) begin
                m_raw[c][t] = WW'(2 * c + t + 1);
                m_bpr[c][t] = enc8_bpr[2 * c + t];
                m_etc[c][t] = enc8_etc[2 * c + t];
            end
        end
    endtask

    task automatic push_bank(input int id, input logic [NC-1:0] caz, input bit lat);
        bank_t b;
        for (int c = 0; c < NC; c++) begin
            for (int t = 0; t < NT; t++) begin
                b.raw[(c*NT+t)*WW +: WW] = m_raw[c][t];
                b.bpr[(c*NT+t)*BW +: BW] = m_bpr[c][t];
                b.etc[(c*NT+t)*EW +: EW] = m_etc[c][t];
            end
        end
        b.caz     = caz;
        b.chk_lat = lat;
        b.id      = id;
        bank_q.push_back(b);
        act_model = b;
    endtask

    // Monitor
    logic [RAWW-1:0] p_raw;
    logic [BPRW-1:0] p_bpr;
    logic [ETCW-1:0] p_etc;
    logic [NC-1:0]   p_caz;
    logic            p_done = 1'b0;
    int              swap_edge = -1;
    int              acc_edge  = -1;
    bit              mon_en    = 1'b0;
    bank_t           mon_b;

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (load_done_o) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: actual pulse at cycle %0d required none", cyc);
                end else begin
                    void'(done_q.pop_front());
                    check("done_latency", 32'(cyc), 32'(acc_edge));
                    check("done_width", 32'(p_done), 32'(0));
                    check("done_shadow_valid", 32'(shadow_valid_o), 32'(1));
                    check("done_busy", 32'(busy_o), 32'(0));
                    check("done_ready", 32'(w_in_ready_o), 32'(0));
                end
            end
            if ({wregs_o, wbprs_o, wetcs_o, col_all_zero_o} !== {p_raw, p_bpr, p_etc, p_caz}) begin
                if (bank_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bank_unexpected: actual change at cycle %0d required none", cyc);
                end else begin
                    mon_b = bank_q.pop_front();
                    check_bank($sformatf("bank%0d", mon_b.id), mon_b);
                    if (mon_b.chk_lat) check("swap_latency", 32'(cyc), 32'(swap_edge));
                end
            end
        end
        if (w_in_valid_i && w_in_ready_o) acc_edge = cyc + 1;
        if (wregs_swap_i) swap_edge = cyc + 1;
        p_raw  = wregs_o;
        p_bpr  = wbprs_o;
        p_etc  = wetcs_o;
        p_caz  = col_all_zero_o;
        p_done = load_done_o;
    end

    // Stimulus
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_row(input bit bc, input logic [3:0] ks, input logic [3:0] nap,
                             input bit expect_done);
        load_start_i  = 1'b1;
        bcast_mode_i  = bc;
        kernel_size_i = ks;
        n_ap_i        = nap;
        if (expect_done) done_q.push_back(1);
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic send(input logic [WW-1:0] d, input int gap);
        bit acc;
        w_in_valid_i = 1'b0;
        repeat (gap) tick();
        w_in_valid_i = 1'b1;
        w_in_data_i  = d;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            acc = w_in_ready_o;
            tick();
            if (acc) break;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: actual no accept in 50 cycles required accept of %0h", d);
        end
    endtask

    task automatic swap();
        wregs_swap_i = 1'b1;
        tick();
        wregs_swap_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        load_start_i  = 1'b0;
        bcast_mode_i  = 1'b0;
        kernel_size_i = '0;
        n_ap_i        = '0;
        w_in_valid_i  = 1'b0;
        w_in_data_i   = '0;
        wregs_swap_i  = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;

        // Reset state
        model_clear();
        act_model.raw = '0;
        act_model.bpr = '0;
        act_model.etc = '0;
        act_model.caz = '1;
        check("reset_ready", 32'(w_in_ready_o), 32'(0));
        check("reset_done", 32'(load_done_o), 32'(0));
        check("reset_shadow_valid", 32'(shadow_valid_o), 32'(0));
        check("reset_busy", 32'(busy_o), 32'(0));
        check_bank("reset", act_model);
        mon_en = 1'b1;

        // Encode with n_ap = 0, broadcast
        model_clear();
        model_bcast(0, 16'h0003, 24'h00000E, 4'd2);
        model_bcast(1, 16'hFFFF, 24'hFFFFFE, 4'd1);
        model_bcast(2, 16'h0000, 24'h000000, 4'd0);
        start_row(1'b1, 4'd3, 4'd0, 1'b1);
        check("busy_in_load", 32'(busy_o), 32'(1));
        send(16'h0003, 0);
        send(16'hFFFF, 0);
        send(16'h0000, 0);
        w_in_valid_i = 1'b0;
        check("ready_after_bcast_row", 32'(w_in_ready_o), 32'(0));
        push_bank(1, 4'b0000, 1'b1);
        swap();
        repeat (2) tick();

        // Per-column, gap-free
        model_percol();
        start_row(1'b0, 4'd2, 4'd0, 1'b1);
        for (int k = 0; k < 8; k++) send(WW'(k + 1), 0);
        w_in_valid_i = 1'b0;
        check("ready_drop_after_8th", 32'(w_in_ready_o), 32'(0));
        push_bank(2, 4'b0000, 1'b1);
        swap();
        repeat (2) tick();

        // Approximation n_ap = 2: raw kept, encoding all zero
        model_clear();
        for (int t = 0; t < 3; t++) model_bcast(t, 16'h0003, 24'h0, 4'd0);
        start_row(1'b1, 4'd3, 4'd2, 1'b1);
        for (int k = 0; k < 3; k++) send(16'h0003, 0);
        w_in_valid_i = 1'b0;
        push_bank(3, 4'b1111, 1'b1);
        swap();
        repeat (2) tick();

        // Per-column with random gaps and an ignored load_start mid-row
        model_percol();
        start_row(1'b0, 4'd2, 4'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                load_start_i  = 1'b1;
                bcast_mode_i  = 1'b1;
                kernel_size_i = 4'd1;
            end
            send(WW'(k + 1), int'($urandom_range(0, 3)));
            load_start_i = 1'b0;
        end
        w_in_valid_i = 1'b0;
        push_bank(4, 4'b0000, 1'b1);
        swap();
        repeat (2) tick();

        // Swap with empty shadow is ignored
        swap();
        repeat (3) tick();
        check_bank("ignored_swap", act_model);
        check("ignored_swap_shadow_valid", 32'(shadow_valid_o), 32'(0));

        // Double buffering: row B loads while per-column row stays active
        start_row(1'b1, 4'd2, 4'd0, 1'b1);
        send(16'h0004, 0);
        send(16'h0002, 0);
        w_in_valid_i = 1'b0;
        repeat (2) tick();
        check_bank("hold_active", act_model);
        check("row_b_shadow_valid", 32'(shadow_valid_o), 32'(1));
        model_clear();
        model_bcast(0, 16'h0004, 24'h10, 4'd1);
        model_bcast(1, 16'h0002, 24'hC, 4'd2);
        push_bank(5, 4'b0000, 1'b1);
        // Same-cycle swap and start: B commits, C starts into the cleared shadow
        wregs_swap_i  = 1'b1;
        load_start_i  = 1'b1;
        bcast_mode_i  = 1'b1;
        kernel_size_i = 4'd1;
        n_ap_i        = 4'd0;
        done_q.push_back(1);
        tick();
        wregs_swap_i = 1'b0;
        load_start_i = 1'b0;
        check("swap_start_busy", 32'(busy_o), 32'(1));
        check("swap_start_shadow_valid", 32'(shadow_valid_o), 32'(0));
        send(16'h0001, 0);
        w_in_valid_i = 1'b0;
        model_clear();
        model_bcast(0, 16'h0001, 24'h2, 4'd1);
        push_bank(6, 4'b0000, 1'b1);
        swap();
        repeat (2) tick();

        // Reset mid-load after 1 of 3 beats
        start_row(1'b1, 4'd3, 4'd0, 1'b0);
        send(16'h0003, 0);
        w_in_valid_i = 1'b0;
        model_clear();
        push_bank(7, 4'b1111, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("post_reset_ready", 32'(w_in_ready_o), 32'(0));
        check("post_reset_busy", 32'(busy_o), 32'(0));
        check("post_reset_shadow_valid", 32'(shadow_valid_o), 32'(0));
        check("post_reset_done", 32'(load_done_o), 32'(0));
        tick();
        check_bank("post_reset", act_model);

        // Fresh load after reset
        start_row(1'b1, 4'd1, 4'd0, 1'b1);
        send(16'hFFFF, 0);
        w_in_valid_i = 1'b0;
        model_clear();
        model_bcast(0, 16'hFFFF, 24'hFFFFFE, 4'd1);
        push_bank(8, 4'b0000, 1'b1);
        swap();
        repeat (3) tick();

        check("done_queue_drained", 32'(done_q.size()), 32'(0));
        check("bank_queue_drained", 32'(bank_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
